fetch_mem_unit: RTL

FETCH_MEM_UNIT -- requirements
Module: fetch_mem_unit

---
 rtl/fetch_mem_unit.sv | 102 ++++++++++
 1 files changed

// File: rtl/fetch_mem_unit.sv
// fetch_mem_unit: multicycle instruction/data memory front end that issues one bus
// transaction per request, with alignment, error and timeout faults.
module fetch_mem_unit #(
  parameter int          TIMEOUT   = 16,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC,
  input  logic [31:0] Adr,
  input  logic [31:0] WriteData,
  input  logic        IrWrite,
  input  logic        AdrSrc,
  input  logic        MemWrite,
  output logic [31:0] Instr,
  output logic [6:0]  Op,
  output logic [2:0]  F3,
  output logic [6:0]  F7,
  output logic [31:0] OldPC,
  output logic [31:0] MemData,
  output logic        Stall,
  output logic        Fault,
  output logic        BusReq,
  output logic        BusWrite,
  output logic [31:0] BusAddr,
  output logic [31:0] BusWData,
  input  logic        BusAck,
  input  logic        BusErr,
  input  logic [31:0] BusRData
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_FAULT} state_t;
  state_t      r_state, w_next;
  logic [31:0] r_instr, r_oldpc, r_memdata, r_addr, r_wdata, r_pc;
  logic        r_write, r_fetch;
  logic [CW-1:0] r_cnt;
  logic        w_start, w_aligned, w_timeout;
  logic [31:0] w_addr;
  assign w_start   = IrWrite | AdrSrc;
  assign w_addr    = AdrSrc ? Adr : PC;
  assign w_aligned = (w_addr[1:0] == 2'b00);
  assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end
  // An ack always wins over the timeout expiring in the same cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_start ? (w_aligned ? S_WAIT : S_FAULT) : S_IDLE;
      S_WAIT:  w_next = BusAck ? (BusErr ? S_FAULT : S_DONE) : (w_timeout ? S_FAULT : S_WAIT);
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_FAULT;
    endcase
  end
  always_comb begin
    BusReq = (r_state == S_WAIT);
    Fault  = (r_state == S_FAULT);
    Stall  = (r_state == S_IDLE) ? w_start : (r_state != S_DONE);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr   <= NOP_INSTR;
      r_oldpc   <= '0;
      r_memdata <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_pc      <= '0;
      r_write   <= 1'b0;
      r_fetch   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      if (r_state == S_IDLE && w_start && w_aligned) begin
        r_addr  <= w_addr;
        r_wdata <= WriteData;
        r_write <= AdrSrc & MemWrite;
        r_fetch <= ~AdrSrc;
        r_pc    <= PC;
        r_cnt   <= '0;
      end
      if (r_state == S_WAIT) begin
        if (w_next != S_WAIT) r_write <= 1'b0;
        if (!BusAck) r_cnt <= r_cnt + 1'b1;
        if (BusAck && !BusErr && r_fetch) begin
          r_instr <= BusRData;
          r_oldpc <= r_pc;
        end
        if (BusAck && !BusErr && !r_fetch && !r_write) r_memdata <= BusRData;
      end
    end
  end
  assign Instr    = r_instr;
  assign Op       = r_instr[6:0];
  assign F3       = r_instr[14:12];
  assign F7       = r_instr[31:25];
  assign OldPC    = r_oldpc;
  assign MemData  = r_memdata;
  assign BusWrite = r_write;
  assign BusAddr  = r_addr;
  assign BusWData = r_wdata;
endmodule
